// File: rtl/risc_pkg.sv
// Shared register-file types: architectural widths and the retiring-result
// record carried through the write buffer.
package risc_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Circular buffer of pending register writes; exposes every slot in age order
// (index 0 = oldest) so the forwarding search can scan without pointer math.
module regfile_wb_fifo
    import risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output wb_entry_t              ents [DEPTH],
    output logic [DEPTH-1:0]       vld
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: slots are only ever read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign ents[g] = mem[rd_ptr + PW'(g)];
        assign vld[g]  = (count > CW'(g));
    end

endmodule

// File: rtl/regfile_wb_lookup.sv
// Priority search over pending writes: the output register is the oldest
// candidate, FIFO slots override it from oldest to youngest.
module regfile_wb_lookup
    import risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [REG_AW-1:0] q,
    input  wb_entry_t         ents [DEPTH],
    input  logic [DEPTH-1:0]  vld,
    input  logic              out_we,
    input  wb_entry_t         out_entry,
    output logic              hit,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (q != '0) begin
            if (out_we && (out_entry.rd == q)) begin
                hit  = 1'b1;
                data = out_entry.data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && (ents[i].rd == q)) begin
                    hit  = 1'b1;
                    data = ents[i].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// Write-side feeder for the register file: buffers retiring results and drains
// one write per cycle, with rs1/rs2 forwarding. Optional REGFILE_WB_BYPASS_EN.
module regfile_write_buffer
    import risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_addr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic [REG_AW-1:0] q_rs1,
    input  logic [REG_AW-1:0] q_rs2,
    output logic              fwd1_hit,
    output logic [XLEN-1:0]   fwd1_data,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd2_data,
    output logic              wb_idle
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          take;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    wb_entry_t     in_entry;
    wb_entry_t     head;
    wb_entry_t     rf_entry;
    wb_entry_t     ents [DEPTH];
    logic [DEPTH-1:0] vld;

    assign in_ready = !rst && (count != CW'(DEPTH));
    // Writes to x0 complete the handshake but are thrown away here.
    assign take     = in_valid && in_ready && (in_rd != '0);
    assign pop      = (count != '0);
    assign in_entry = '{rd: in_rd, data: in_data};

`ifdef REGFILE_WB_BYPASS_EN
    logic bypass;
    assign bypass = take && (count == '0);
    assign push   = take && !bypass;
`else
    assign push   = take;
`endif

    regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .ents       (ents),
        .vld        (vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else if (pop) begin
            rf_we    <= 1'b1;
            rf_addr  <= head.rd;
            rf_wdata <= head.data;
`ifdef REGFILE_WB_BYPASS_EN
        end else if (bypass) begin
            rf_we    <= 1'b1;
            rf_addr  <= in_rd;
            rf_wdata <= in_data;
`endif
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign rf_entry = '{rd: rf_addr, data: rf_wdata};

    regfile_wb_lookup #(.DEPTH(DEPTH)) u_look1 (
        .q         (q_rs1),
        .ents      (ents),
        .vld       (vld),
        .out_we    (rf_we),
        .out_entry (rf_entry),
        .hit       (fwd1_hit),
        .data      (fwd1_data)
    );

    regfile_wb_lookup #(.DEPTH(DEPTH)) u_look2 (
        .q         (q_rs2),
        .ents      (ents),
        .vld       (vld),
        .out_we    (rf_we),
        .out_entry (rf_entry),
        .hit       (fwd2_hit),
        .data      (fwd2_data)
    );

    assign wb_idle = (count == '0) && !rf_we;

endmodule
